// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sequencer that shares one UART transmitter
// among NUM_REQ byte requesters. It supports packet locking and has a watchdog
// for a transmitter that never raises busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         TxData,
  output logic                          transmit,
  input  logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_active,
  output logic                          timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TCW = $clog2(BUSY_TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic                  locked_q, locked_d;
  logic [TCW-1:0]        tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_q, tx_d;
  logic                  act_q, act_d;
  logic                  terr_q, terr_d;

  logic                  pick_vld;
  logic [IDW-1:0]        pick_idx;

  // Successor of a requester index, wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // Pick the candidate: only the owner while a packet is locked, otherwise the
  // first valid requester searching upward from ptr (descending loop leaves the
  // smallest offset as the final assignment).
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    if (locked_q) begin
      pick_vld = req_valid[owner_q];
      pick_idx = owner_q;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[IDW'((int'(ptr_q) + k) % NUM_REQ)]) begin
          pick_vld = 1'b1;
          pick_idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
        end
      end
    end
  end

  // Next-state logic for the issue / wait-for-busy / wait-for-done sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    tcnt_d   = tcnt_q;
    data_d   = data_q;
    act_d    = act_q;
    ready_d  = '0;
    tx_d     = 1'b0;
    terr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld && !busy) begin
          data_d   = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          tx_d     = 1'b1;
          ready_d  = NUM_REQ'(1) << pick_idx;
          owner_d  = pick_idx;
          act_d    = 1'b1;
          locked_d = !req_last[pick_idx];
          tcnt_d   = '0;
          state_d  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == TCW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte, release any lock and
          // move fairness past the stuck owner.
          terr_d   = 1'b1;
          locked_d = 1'b0;
          ptr_d    = inc_wrap(owner_q);
          act_d    = 1'b0;
          state_d  = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          state_d = S_IDLE;
          if (!locked_q) begin
            ptr_d = inc_wrap(owner_q);
            act_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any lock, owner and pending pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      tcnt_q   <= '0;
      ready_q  <= '0;
      data_q   <= '0;
      tx_q     <= 1'b0;
      act_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      tcnt_q   <= tcnt_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      act_q    <= act_d;
      terr_q   <= terr_d;
    end
  end

  assign req_ready    = ready_q;
  assign TxData       = data_q;
  assign transmit     = tx_q;
  assign grant_id     = owner_q;
  assign grant_active = act_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues feed the DUT, a small
// transmitter model produces busy, and a scoreboard of expected grants is
// compared on every transmit pulse.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   TxData;
  logic            transmit;
  logic            busy = 1'b0;
  logic [1:0]      grant_id;
  logic            grant_active;
  logic            timeout_err;

  typedef struct packed { logic [7:0] d; logic l; } rq_t;
  typedef struct packed { logic [1:0] id; logic [7:0] d; } exp_t;

  rq_t  rq [N][$];
  exp_t exp_q[$];

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  logic model_en = 1'b1;
  logic [N-1:0] acc_s;
  logic tx_s;
  int   pre = 0;
  int   blen = 0;
  logic prev_tx = 1'b0;
  exp_t mon_e;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .TxData(TxData),
    .transmit(transmit), .busy(busy), .grant_id(grant_id),
    .grant_active(grant_active), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic l);
    rq_t r;
    r.d = d;
    r.l = l;
    rq[id].push_back(r);
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id[1:0];
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int maxc);
    int  k = 0;
    bit  done = 1'b0;
    while (!done && k < maxc) begin
      @(negedge clk);
      k++;
      done = (exp_q.size() == 0) && (rq[0].size() == 0) && (rq[1].size() == 0) &&
             (rq[2].size() == 0) && (rq[3].size() == 0) && !busy && !grant_active && !transmit;
    end
    check(tag, done, 1);
  endtask

  always @(posedge clk) cyc++;

  // Requesters: hold the head byte until req_ready is sampled high at an edge.
  always @(posedge clk) begin
    acc_s = req_ready;
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = rq[i][0].l;
        req_data[i*DW +: DW] = rq[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  end

  // Transmitter model: busy rises 2 cycles after transmit and lasts 10 cycles.
  always @(posedge clk) begin
    tx_s = transmit;
    #1;
    if (!model_en) begin
      busy = 1'b0;
      pre  = 0;
      blen = 0;
    end else begin
      if (tx_s) pre = 2;
      if (pre > 0) begin
        pre--;
        if (pre == 0) begin
          busy = 1'b1;
          blen = 10;
        end
      end else if (blen > 0) begin
        blen--;
        if (blen == 0) busy = 1'b0;
      end
    end
  end

  // Scoreboard: every transmit pulse must match the next expected grant.
  always @(negedge clk) begin
    if (reset && transmit) begin
      check("exp_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("grant_id", grant_id, mon_e.id);
        check("TxData", TxData, mon_e.d);
        check("req_ready", req_ready, 32'd1 << mon_e.id);
        check("grant_active_tx", grant_active, 1);
      end
      check("tx_single_cycle", prev_tx, 0);
    end
    prev_tx = transmit;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    int t0;
    int t1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_transmit", transmit, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_TxData", TxData, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_grant_active", grant_active, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;

    // Single byte from requester 2
    expect_tx(2, 8'hA5);
    send(2, 8'hA5, 1'b1);
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    check("single_busy_seen", busy, 1);
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    check("single_ga_busy_fall", grant_active, 1);
    check("single_gid", grant_id, 2);
    @(negedge clk);
    check("single_ga_after", grant_active, 0);
    check("single_gid_after", grant_id, 2);
    drain("single_drain", 100);

    // Round-robin from ptr=0 after reset
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) expect_tx(i, 8'h10 + 8'(i));
    for (int i = 0; i < N; i++) expect_tx(i, 8'h20 + 8'(i));
    for (int i = 0; i < N; i++) begin
      send(i, 8'h10 + 8'(i), 1'b1);
      send(i, 8'h20 + 8'(i), 1'b1);
    end
    drain("rr_drain", 600);

    // Packet lock: requester 1 sends 1a,1b,1c uninterrupted while 0 waits
    expect_tx(0, 8'h30);
    expect_tx(1, 8'h1A);
    expect_tx(1, 8'h1B);
    expect_tx(1, 8'h1C);
    expect_tx(0, 8'h31);
    send(0, 8'h30, 1'b1);
    send(0, 8'h31, 1'b1);
    send(1, 8'h1A, 1'b0);
    send(1, 8'h1B, 1'b0);
    send(1, 8'h1C, 1'b1);
    drain("lock_drain", 400);

    // Watchdog: busy never rises; lock on requester 1 is released, 2 served next
    model_en = 1'b0;
    expect_tx(1, 8'h40);
    expect_tx(2, 8'h50);
    expect_tx(1, 8'h41);
    send(1, 8'h40, 1'b0);
    send(1, 8'h41, 1'b1);
    send(2, 8'h50, 1'b1);
    k = 0;
    while (!transmit && k < 20) begin @(negedge clk); k++; end
    check("wd_tx_seen", transmit, 1);
    t0 = cyc;
    k = 0;
    do begin @(negedge clk); k++; end while (!timeout_err && k < 40);
    t1 = cyc;
    check("wd_latency", t1 - t0, TO);
    check("wd_ga_dropped", grant_active, 0);
    @(negedge clk);
    check("wd_pulse_len", timeout_err, 0);
    drain("wd_drain", 200);
    model_en = 1'b1;

    // Wrap-around: after serving 2, ptr=3 -> 3 before 0
    expect_tx(2, 8'h60);
    expect_tx(3, 8'h63);
    expect_tx(0, 8'h70);
    send(2, 8'h60, 1'b1);
    send(3, 8'h63, 1'b1);
    send(0, 8'h70, 1'b1);
    drain("wrap_drain", 200);

    // Reset during WAIT_DONE of a locked packet
    expect_tx(1, 8'h80);
    send(1, 8'h80, 1'b0);
    send(1, 8'h81, 1'b1);
    send(0, 8'h90, 1'b1);
    k = 0;
    while (!busy && k < 30) begin @(negedge clk); k++; end
    check("mid_busy_seen", busy, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_en = 1'b0;
    #1;
    check("mid_transmit", transmit, 0);
    check("mid_req_ready", req_ready, 0);
    check("mid_TxData", TxData, 0);
    check("mid_grant_id", grant_id, 0);
    check("mid_grant_active", grant_active, 0);
    check("mid_timeout_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    expect_tx(0, 8'h90);
    expect_tx(1, 8'h81);
    model_en = 1'b1;
    reset = 1'b1;
    drain("mid_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
